mem_request_arbiter: RTL and testbench
======================================

Name: mem_request_arbiter

Overview:
- Upstream stage of mem_controller. Arbitrates between two memory clients (A, B) with round-robin priority.
- Issues the one-cycle req pulse that starts a DRAM access cycle, then holds the granted address for the full access.
- Drives the multiplexed DRAM address bus: row half while mux_in=0, column half while mux_in=1, with mux_in taken from mem_controller.
- Returns a one-cycle ack pulse to the served client.

Parameters:
- ADDR_W, 16, client address width; must be even. Upper ADDR_W/2 bits are the row, lower ADDR_W/2 bits are the column.
- BUSY_CYCLES, 4, number of clk_in cycles the downstream controller needs after it samples req. Legal range 1..15.

Ports:
- clk_in  input  1  system clock, all logic on posedge
- rst_in  input  1  synchronous, active-high reset
- a_req_in  input  1  client A request, level; held until a_ack_out seen
- a_addr_in  input  ADDR_W  client A address; stable while a_req_in=1
- b_req_in  input  1  client B request, level
- b_addr_in  input  ADDR_W  client B address
- mux_in  input  1  row/column select from mem_controller
- req_out  output  1  access start pulse to mem_controller
- dram_addr_out  output  ADDR_W/2  multiplexed row/column address
- a_ack_out  output  1  one-cycle completion pulse to A
- b_ack_out  output  1  one-cycle completion pulse to B
- busy_out  output  1  high in every state except IDLE

Behaviour:
- Reset (rst_in=1 at posedge) has priority over everything, including mid-access:
  - state=IDLE; req_out, a_ack_out, b_ack_out = 0; addr_q=0; cnt=0; owner=A; last_grant=B, so A wins the first tie.
  - Consequence: dram_addr_out=0 after reset.
- FSM states: IDLE, ISSUE, WAIT, DONE. All outputs except dram_addr_out are registered.
- IDLE:
  - No request pending: stay in IDLE.
  - Only one request pending: grant that client.
  - Both pending: grant the client not equal to last_grant.
  - On grant: latch the client address into addr_q, set owner and last_grant, set req_out=1, go to ISSUE.
- ISSUE (one cycle): mem_controller samples req_out=1 at the exit edge. Set req_out=0, cnt=0, go to WAIT.
- WAIT:
  - cnt increments each cycle.
  - When cnt reaches BUSY_CYCLES-1, go to DONE and assert the ack of owner (registered, high for exactly the DONE cycle).
- DONE (one cycle): clear the ack, go to IDLE. The client must drop its req at the edge ending DONE.
- Timing with default parameters:
  - Grant edge E0; req_out high E0..E1; ack high E5..E6.
  - Request-sampled-to-ack latency is 5 cycles.
  - Minimum spacing between successive req_out pulses is 7 cycles.
- dram_addr_out is combinational: mux_in ? addr_q[ADDR_W/2-1:0] : addr_q[ADDR_W-1:ADDR_W/2].
- addr_q changes only on a grant edge in IDLE. Client address changes during an access have no effect.
- Request handling outside IDLE:
  - Requests arriving in ISSUE, WAIT or DONE stay pending and are considered only in IDLE.
  - A request dropped before grant is simply not served; no error is signalled.
- Never both acks high; never req_out and any ack high together; req_out never high for more than one consecutive cycle.

Decomposition:
- Shared package mem_pkg:
  - State encoding constants: IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, DONE=2'd3.
  - Client id constants CLIENT_A=1'b0, CLIENT_B=1'b1.
  - Default BUSY_CYCLES=4, so mem_controller and its bench share the same value.
- One natural sub-module, rr_arbiter2: combinational two-way round-robin pick from {a_req, b_req, last_grant} giving {grant_valid, grant_id}. FSM, counter and address register stay in the top module.

Test Plan:
- Reset then idle 10 cycles -> req_out, a_ack_out, b_ack_out, busy_out all 0; dram_addr_out=8'h00.
- A alone, a_addr_in=16'hA5C3, mux_in driven by a real mem_controller:
  - req_out high exactly 1 cycle after the grant edge.
  - dram_addr_out=8'hA5 while mux_in=0 and 8'hC3 while mux_in=1.
  - a_ack_out high exactly 1 cycle, 5 cycles after req_out sampled; b_ack_out stays 0.
- A and B both requesting continuously from reset (A=16'h1111, B=16'h2222) -> grants in order A, B, A, B; req_out pulses 7 cycles apart; acks alternate.
- Change a_addr_in from 16'h1234 to 16'hFFFF during WAIT -> dram_addr_out remains 8'h12/8'h34 for the whole access.
- Assert rst_in for one cycle during WAIT of a B access:
  - Next cycle: state IDLE, busy_out=0, no b_ack_out ever issued for that access.
  - With B still requesting, the new grant goes to A if A is also requesting, since last_grant resets to B.
- Random request traffic for 2000 cycles -> assertions hold: one-hot acks, single-cycle req_out, ack count equals req_out count.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory request path: FSM state encoding,
// client identifiers and the default downstream access length.
package mem_pkg;

   // Arbiter FSM state encoding
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   // Client identifiers
   localparam logic CLIENT_A = 1'b0;
   localparam logic CLIENT_B = 1'b1;

   // Cycles mem_controller stays busy after sampling req; shared with its bench
   localparam int BUSY_CYCLES_DEFAULT = 4;

   // Width of the access-length counter (BUSY_CYCLES legal range 1..15)
   localparam int CNT_W = 4;

endpackage : mem_pkg

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick. A lone requester always wins; on a tie the
// client that was not granted last time wins.
module rr_arbiter2
   import mem_pkg::*;
(
   input  logic a_req_in,
   input  logic b_req_in,
   input  logic last_grant_in,
   output logic grant_valid_out,
   output logic grant_id_out
);

   // Combinational grant selection
   always_comb begin
      grant_valid_out = a_req_in | b_req_in;
      grant_id_out    = CLIENT_A;
      if (a_req_in && b_req_in) begin
         grant_id_out = ~last_grant_in;
      end else if (b_req_in) begin
         grant_id_out = CLIENT_B;
      end
   end

endmodule : rr_arbiter2

// File: rtl/mem_request_arbiter.sv
// Front end of mem_controller: picks one of two clients round-robin, issues
// a single-cycle req pulse, holds the granted address for the whole access
// and returns a single-cycle ack to the served client.
//
// Handshake: a client raises its req level with a stable address and holds
// both until it sees its ack; it drops req at the edge that ends the ack
// cycle. Requests are only looked at in IDLE, so anything raised while an
// access is in flight simply waits. req_out is a one-cycle start strobe with
// no back-pressure: mem_controller is assumed to sample it unconditionally.
module mem_request_arbiter
   import mem_pkg::*;
#(
   parameter int ADDR_W      = 16,
   parameter int BUSY_CYCLES = BUSY_CYCLES_DEFAULT
) (
   input  logic                clk_in,
   input  logic                rst_in,
   input  logic                a_req_in,
   input  logic [ADDR_W-1:0]   a_addr_in,
   input  logic                b_req_in,
   input  logic [ADDR_W-1:0]   b_addr_in,
   input  logic                mux_in,
   output logic                req_out,
   output logic [ADDR_W/2-1:0] dram_addr_out,
   output logic                a_ack_out,
   output logic                b_ack_out,
   output logic                busy_out,
   output logic [1:0]          state_dbg_out
);

   localparam int HALF = ADDR_W / 2;
   // WAIT ends when the counter has reached this value
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_CYCLES - 1);

   logic [1:0]        state_q, state_d;
   logic              req_q, req_d;
   logic              a_ack_q, a_ack_d;
   logic              b_ack_q, b_ack_d;
   logic              busy_q, busy_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              owner_q, owner_d;
   logic              last_grant_q, last_grant_d;

   logic              grant_valid;
   logic              grant_id;

   rr_arbiter2 u_rr_arbiter2 (
      .a_req_in        (a_req_in),
      .b_req_in        (b_req_in),
      .last_grant_in   (last_grant_q),
      .grant_valid_out (grant_valid),
      .grant_id_out    (grant_id)
   );

   // Next-state logic for the access FSM, counter, address and grant history
   always_comb begin
      state_d      = state_q;
      req_d        = 1'b0;
      a_ack_d      = 1'b0;
      b_ack_d      = 1'b0;
      addr_d       = addr_q;
      cnt_d        = cnt_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      case (state_q)
         IDLE: begin
            if (grant_valid) begin
               addr_d       = (grant_id == CLIENT_B) ? b_addr_in : a_addr_in;
               owner_d      = grant_id;
               last_grant_d = grant_id;
               req_d        = 1'b1;
               state_d      = ISSUE;
            end
         end
         ISSUE: begin
            // mem_controller samples req_out at the edge leaving this state
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            if (cnt_q == CNT_LAST) begin
               a_ack_d = (owner_q == CLIENT_A);
               b_ack_d = (owner_q == CLIENT_B);
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // State registers; reset wins over any access in flight
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q      <= IDLE;
         req_q        <= 1'b0;
         a_ack_q      <= 1'b0;
         b_ack_q      <= 1'b0;
         busy_q       <= 1'b0;
         addr_q       <= '0;
         cnt_q        <= '0;
         owner_q      <= CLIENT_A;
         last_grant_q <= CLIENT_B;
      end else begin
         state_q      <= state_d;
         req_q        <= req_d;
         a_ack_q      <= a_ack_d;
         b_ack_q      <= b_ack_d;
         busy_q       <= busy_d;
         addr_q       <= addr_d;
         cnt_q        <= cnt_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
      end
   end

   // Row half while mux_in=0, column half while mux_in=1
   always_comb begin
      dram_addr_out = mux_in ? addr_q[HALF-1:0] : addr_q[ADDR_W-1:HALF];
   end

   assign req_out       = req_q;
   assign a_ack_out     = a_ack_q;
   assign b_ack_out     = b_ack_q;
   assign busy_out      = busy_q;
   assign state_dbg_out = state_q;

endmodule : mem_request_arbiter

// File: tb/tb_mem_request_arbiter.sv
// Bench for mem_request_arbiter: access-level reference model with an
// expected-owner queue, a per-cycle compare process, and directed scenarios
// with hand-computed expectations.
module tb_mem_request_arbiter;

   localparam int ADDR_W = 16;
   localparam int BUSY   = 4;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        rst_in = 1'b1;
   logic        a_req_in = 1'b0;
   logic [15:0] a_addr_in = '0;
   logic        b_req_in = 1'b0;
   logic [15:0] b_addr_in = '0;
   logic        mux_in = 1'b0;
   logic        req_out;
   logic [7:0]  dram_addr_out;
   logic        a_ack_out;
   logic        b_ack_out;
   logic        busy_out;
   logic [1:0]  state_dbg_out;

   always #5 clk = ~clk;

   mem_request_arbiter #(.ADDR_W(ADDR_W), .BUSY_CYCLES(BUSY)) dut (
      .clk_in        (clk),
      .rst_in        (rst_in),
      .a_req_in      (a_req_in),
      .a_addr_in     (a_addr_in),
      .b_req_in      (b_req_in),
      .b_addr_in     (b_addr_in),
      .mux_in        (mux_in),
      .req_out       (req_out),
      .dram_addr_out (dram_addr_out),
      .a_ack_out     (a_ack_out),
      .b_ack_out     (b_ack_out),
      .busy_out      (busy_out),
      .state_dbg_out (state_dbg_out)
   );

   int chk_cnt  = 0;
   int pass_cnt = 0;
   int cyc      = 0;
   int req_cnt  = 0;
   int ack_cnt  = 0;
   bit cmp_en   = 1'b0;
   bit want_a   = 1'b0;
   bit want_b   = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // ---------------- driver processes ----------------
   // Clients: raise req while wanted, drop it in the ack cycle
   always @(negedge clk) begin
      if (a_ack_out || !want_a) a_req_in <= 1'b0;
      else                      a_req_in <= 1'b1;
      if (b_ack_out || !want_b) b_req_in <= 1'b0;
      else                      b_req_in <= 1'b1;
   end

   // Stand-in mem_controller: row phase, then column phase, then row again
   int mc_cnt = 0;
   always @(negedge clk) begin
      if (rst_in) begin
         mc_cnt <= 0;
         mux_in <= 1'b0;
      end else begin
         if (req_out)                     mc_cnt <= 1;
         else if (mc_cnt != 0 && mc_cnt < 7) mc_cnt <= mc_cnt + 1;
         else                             mc_cnt <= 0;
         mux_in <= (mc_cnt >= 2 && mc_cnt <= 4);
      end
   end

   // ---------------- reference model ----------------
   // An access is tracked as "cycles since its grant edge": req in cycle 0,
   // ack in cycle BUSY+1, idle again after that.
   int          m_phase = -1;
   logic        m_owner = 1'b0;
   logic        m_last  = 1'b1;
   logic [15:0] m_addr  = '0;
   logic [0:0]  exp_q[$];

   function automatic logic pick(input logic a, input logic b, input logic last);
      if (a && b) return !last;
      return b;
   endfunction

   always @(posedge clk) begin
      if (rst_in) begin
         m_phase <= -1;
         m_owner <= 1'b0;
         m_last  <= 1'b1;
         m_addr  <= '0;
         exp_q.delete();
      end else if (m_phase < 0) begin
         if (a_req_in || b_req_in) begin
            m_owner <= pick(a_req_in, b_req_in, m_last);
            m_last  <= pick(a_req_in, b_req_in, m_last);
            m_addr  <= pick(a_req_in, b_req_in, m_last) ? b_addr_in : a_addr_in;
            m_phase <= 0;
            exp_q.push_back(pick(a_req_in, b_req_in, m_last));
         end
      end else begin
         m_phase <= (m_phase == BUSY + 1) ? -1 : m_phase + 1;
      end
   end

   // ---------------- compare process / scoreboard ----------------
   logic [11:0] exp_vec;
   logic [11:0] act_vec;
   logic        prev_req = 1'b0;
   logic [0:0]  exp_id;

   always begin
      @(posedge clk);
      #2;
      if (cmp_en) begin
         exp_vec = {m_phase == 0,
                    (m_phase == BUSY + 1) && !m_owner,
                    (m_phase == BUSY + 1) && m_owner,
                    m_phase >= 0,
                    mux_in ? m_addr[7:0] : m_addr[15:8]};
         act_vec = {req_out, a_ack_out, b_ack_out, busy_out, dram_addr_out};
         check("cycle", 32'(act_vec), 32'(exp_vec));
         check("protocol", {29'd0, a_ack_out & b_ack_out,
                            req_out & (a_ack_out | b_ack_out), req_out & prev_req}, 32'd0);
         if (a_ack_out || b_ack_out) begin
            ack_cnt++;
            if (exp_q.size() == 0) begin
               check("ack_unexpected", 32'd1, 32'd0);
            end else begin
               exp_id = exp_q.pop_front();
               check("ack_owner", {31'd0, b_ack_out}, {31'd0, exp_id});
            end
         end
         if (req_out) req_cnt++;
         prev_req = req_out;
      end
   end

   // ---------------- stimulus helpers ----------------
   function automatic bit sig_sel(input int which);
      case (which)
         0:       return req_out;
         1:       return a_ack_out;
         2:       return b_ack_out;
         default: return a_ack_out | b_ack_out;
      endcase
   endfunction

   task automatic wait_for(input int which, input int max_cyc, output int at_cyc);
      at_cyc = -1;
      for (int i = 0; i < max_cyc; i++) begin
         step();
         if (sig_sel(which)) begin
            at_cyc = cyc;
            break;
         end
      end
      if (at_cyc < 0) check($sformatf("timeout_%0d", which), 32'd0, 32'd1);
   endtask

   task automatic do_reset();
      rst_in = 1'b1;
      step();
      step();
      rst_in = 1'b0;
   endtask

   task automatic drain();
      want_a = 1'b0;
      want_b = 1'b0;
      for (int i = 0; i < 12; i++) step();
   endtask

   // ---------------- directed and random scenarios ----------------
   int t_req, t_ack, n_req, n_ack, t_tmp;
   int req_at[8];
   int ack_id[8];
   bit saw_row, saw_col;

   initial begin
      // Reset then idle
      do_reset();
      cmp_en = 1'b1;
      for (int i = 0; i < 10; i++) step();
      check("idle_req",   {31'd0, req_out},   32'd0);
      check("idle_a_ack", {31'd0, a_ack_out}, 32'd0);
      check("idle_b_ack", {31'd0, b_ack_out}, 32'd0);
      check("idle_busy",  {31'd0, busy_out},  32'd0);
      check("idle_dram",  {24'd0, dram_addr_out}, 32'h00);
      check("idle_state", {30'd0, state_dbg_out}, 32'd0);

      // Client A alone
      a_addr_in = 16'hA5C3;
      want_a    = 1'b1;
      wait_for(0, 20, t_req);
      check("a_model_addr", {16'd0, m_addr}, 32'h0000A5C3);
      step();
      check("a_req_one_cycle", {31'd0, req_out}, 32'd0);
      saw_row = 1'b0;
      saw_col = 1'b0;
      t_ack   = -1;
      for (int i = 0; i < 10; i++) begin
         if (a_ack_out) begin
            t_ack = cyc;
            break;
         end
         if (mux_in) saw_col = 1'b1;
         else        saw_row = 1'b1;
         check("a_dram", {24'd0, dram_addr_out}, mux_in ? 32'hC3 : 32'hA5);
         step();
      end
      want_a = 1'b0;
      check("a_ack_latency", 32'(t_ack - t_req), 32'd5);
      check("a_no_b_ack", {31'd0, b_ack_out}, 32'd0);
      check("a_both_halves", {30'd0, saw_row, saw_col}, 32'd3);
      step();
      check("a_ack_one_cycle", {31'd0, a_ack_out}, 32'd0);
      drain();

      // A and B requesting continuously from reset
      do_reset();
      a_addr_in = 16'h1111;
      b_addr_in = 16'h2222;
      want_a = 1'b1;
      want_b = 1'b1;
      n_req = 0;
      n_ack = 0;
      for (int i = 0; i < 60 && n_ack < 4; i++) begin
         step();
         if (req_out && n_req < 8) begin
            req_at[n_req] = cyc;
            n_req++;
         end
         if ((a_ack_out || b_ack_out) && n_ack < 8) begin
            ack_id[n_ack] = b_ack_out ? 1 : 0;
            n_ack++;
         end
      end
      want_a = 1'b0;
      want_b = 1'b0;
      check("rr_ack_count", 32'(n_ack), 32'd4);
      check("rr_order", {28'd0, ack_id[0][0], ack_id[1][0], ack_id[2][0], ack_id[3][0]}, 32'b0101);
      check("rr_gap_1", 32'(req_at[1] - req_at[0]), 32'd7);
      check("rr_gap_2", 32'(req_at[2] - req_at[1]), 32'd7);
      check("rr_gap_3", 32'(req_at[3] - req_at[2]), 32'd7);
      drain();

      // Client address changes during the access are ignored
      a_addr_in = 16'h1234;
      want_a    = 1'b1;
      wait_for(0, 20, t_req);
      step();
      step();
      a_addr_in = 16'hFFFF;
      for (int i = 0; i < 10; i++) begin
         if (a_ack_out) break;
         check("hold_dram", {24'd0, dram_addr_out}, mux_in ? 32'h34 : 32'h12);
         step();
      end
      want_a = 1'b0;
      check("hold_dram_ack", {24'd0, dram_addr_out}, mux_in ? 32'h34 : 32'h12);
      drain();

      // Reset in the middle of a B access
      b_addr_in = 16'hBEEF;
      a_addr_in = 16'h5A5A;
      want_b    = 1'b1;
      wait_for(0, 20, t_req);
      step();
      step();
      want_a = 1'b1;
      rst_in = 1'b1;
      step();
      rst_in = 1'b0;
      check("rst_busy",  {31'd0, busy_out},  32'd0);
      check("rst_state", {30'd0, state_dbg_out}, 32'd0);
      check("rst_req",   {31'd0, req_out},   32'd0);
      check("rst_b_ack", {31'd0, b_ack_out}, 32'd0);
      wait_for(3, 20, t_tmp);
      check("rst_first_ack_is_a", {30'd0, a_ack_out, b_ack_out}, 32'b10);
      want_a = 1'b0;
      wait_for(2, 20, t_tmp);
      want_b = 1'b0;
      drain();

      // Random request traffic
      req_cnt = 0;
      ack_cnt = 0;
      for (int i = 0; i < 2000; i++) begin
         step();
         if ($urandom_range(0, 7) == 0) want_a = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 7) == 0) want_b = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) a_addr_in = 16'($urandom);
         if ($urandom_range(0, 3) == 0) b_addr_in = 16'($urandom);
      end
      drain();
      check("rand_req_vs_ack", 32'(req_cnt), 32'(ack_cnt));
      check("rand_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   // Absolute time limit
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule : tb_mem_request_arbiter
